// File: rtl/apb_ral_apb_master_if.sv
// rtl/apb_ral_apb_master_if.sv - command/response port and APB3 bus bundle for apb_ral_apb_master
interface apb_ral_apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_ral_apb_master.sv
// rtl/apb_ral_apb_master.sv - APB3 requester turning a valid/ready command into SETUP/ACCESS transfers
// Optional ACCESS-phase wait limit enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_ral_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  pclk,
  input logic                  preset,
  apb_ral_apb_master_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_ready;
  logic              accept;
  logic              timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_SETUP)                        wait_cnt_d = '0;
    else if (state_q == ST_ACCESS && !bus.pready)   wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // The limit is hit on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout = (state_q == ST_ACCESS) && !bus.pready && (wait_cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // A timeout only fires with pready low, so it never opens a back-to-back accept.
  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_ACCESS && bus.pready);
  assign accept    = bus.cmd_valid && cmd_ready;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
          state_d     = accept ? ST_SETUP : ST_IDLE;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      paddr_d  = bus.cmd_addr;
      pwrite_d = bus.cmd_write;
      pwdata_d = bus.cmd_wdata;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.psel      = (state_q != ST_IDLE);
  assign bus.penable   = (state_q == ST_ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_ral_apb_master.sv
// tb/tb_apb_ral_apb_master.sv - self-checking bench for apb_ral_apb_master
// Covers APB_MASTER_TIMEOUT_EN when the macro is defined for the build.
module tb_apb_ral_apb_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic pclk   = 1'b0;
  logic preset = 1'b1;

  apb_ral_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_ral_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    int   waits;
    logic err;
  } scfg_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    logic        err;
    logic [31:0] erd;
    logic        eerr;
    int          lat;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          psel_falls = 0;
  logic        psel_prev  = 1'b0;

  exp_t        exp_q[$];
  scfg_t       scfg_q[$];
  logic [31:0] smem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  // Slave: per-transfer wait states and error, backed by its own memory.
  scfg_t cur;
  int    acc_n = 0;
  always @(posedge pclk) begin
    #1;
    if (bus.psel && bus.penable) begin
      if (acc_n == 0) cur = (scfg_q.size() != 0) ? scfg_q.pop_front() : '{0, 1'b0};
      bus.pready = (acc_n >= cur.waits);
      if (bus.pready) begin
        bus.prdata  = bus.pwrite ? $urandom : (smem.exists(bus.paddr) ? smem[bus.paddr] : 32'h0);
        bus.pslverr = cur.err;
        if (bus.pwrite) smem[bus.paddr] = bus.pwdata;
      end else begin
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);
      end
      acc_n++;
    end else begin
      acc_n       = 0;
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
    end
  end

  exp_t mon_e;
  always @(negedge pclk) begin
    if (!preset) begin
      if (psel_prev && !bus.psel) psel_falls++;
      psel_prev = bus.psel;
      if (bus.psel && bus.penable) begin
        if (exp_q.size() == 0) fail("bus_access_without_command");
        else begin
          check("paddr", bus.paddr, exp_q[0].a);
          check("pwrite", bus.pwrite, exp_q[0].w);
          if (exp_q[0].w) check("pwdata", bus.pwdata, exp_q[0].d);
        end
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) fail("unexpected_rsp_valid");
        else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
          check("rsp_err", bus.rsp_err, mon_e.err);
          check("rsp_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                       input logic err, input logic [31:0] erd, input logic eerr, input int lat);
    bit got = 0;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge pclk);
      if (bus.cmd_ready) got = 1;
    end
    if (!got) begin
      fail("cmd_accept_timeout");
      return;
    end
    scfg_q.push_back('{waits, err});
    exp_q.push_back('{w, a, d, erd, eerr, cyc + lat});
    if (w) ref_mem[a] = d;
  endtask

  task automatic drop();
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge pclk);
    if (exp_q.size() != 0) begin
      fail("response_drain_timeout");
      exp_q.delete();
    end
  endtask

  vec_t vecs[9];

  initial begin
    int f0;
    int rsp_seen;
    logic w, err;
    logic [31:0] a, d, erd;
    int waits;

    vecs[0] = '{1'b1, 32'h1000, 32'h0000_0005, 0, 1'b0, 32'h0,         1'b0, 3};
    vecs[1] = '{1'b0, 32'h1000, 32'h0,         0, 1'b0, 32'h0000_0005, 1'b0, 3};
    vecs[2] = '{1'b1, 32'h0010, 32'h0BAD_F00D, 0, 1'b0, 32'h0,         1'b0, 3};
    vecs[3] = '{1'b0, 32'h0010, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h1004, 32'h0,         3, 1'b0, 32'h0,         1'b0, 6};
    vecs[5] = '{1'b0, 32'h1000, 32'h0,         0, 1'b1, 32'h0000_0005, 1'b1, 3};
    vecs[6] = '{1'b0, 32'h0010, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 1'b0, 3};
    vecs[7] = '{1'b1, 32'h1004, 32'hA5A5_0001, 2, 1'b1, 32'h0,         1'b1, 5};
    vecs[8] = '{1'b0, 32'h1004, 32'h0,         1, 1'b0, 32'hA5A5_0001, 1'b0, 4};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    repeat (2) @(posedge pclk);
    #1;
    check("reset_psel", bus.psel, 0);
    check("reset_penable", bus.penable, 0);
    check("reset_pwrite", bus.pwrite, 0);
    check("reset_paddr", bus.paddr, 0);
    check("reset_pwdata", bus.pwdata, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    @(posedge pclk); #2;
    preset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].waits, vecs[i].err,
            vecs[i].erd, vecs[i].eerr, vecs[i].lat);
      drop();
      @(negedge pclk);
      check("setup_psel", bus.psel, 1);
      check("setup_penable", bus.penable, 0);
      @(negedge pclk);
      check("access_psel", bus.psel, 1);
      check("access_penable", bus.penable, 1);
      drain();
    end

    // Back-to-back write then read with cmd_valid held: psel must stay high between them.
    f0 = psel_falls;
    issue(1'b1, 32'h0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, 3);
    issue(1'b0, 32'h0010, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    drop();
    drain();
    check("b2b_psel_falls", psel_falls - f0, 1);

    // Reset during ACCESS aborts the transfer without a response.
    issue(1'b0, 32'h1000, 32'h0, 8, 1'b0, 32'h0000_0005, 1'b0, 11);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.penable; i++) @(negedge pclk);
    @(posedge pclk); #2;
    preset = 1'b1;
    #1;
    check("abort_psel", bus.psel, 0);
    check("abort_penable", bus.penable, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    exp_q.delete();
    scfg_q.delete();
    repeat (3) @(posedge pclk);
    #2;
    preset = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) rsp_seen++;
    end
    check("abort_no_rsp", rsp_seen, 0);
    issue(1'b0, 32'h1000, 32'h0, 0, 1'b0, 32'h0000_0005, 1'b0, 3);
    drop();
    drain();

`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h1000, 32'h0, 100, 1'b0, 32'h0, 1'b1, 6);
    drop();
    drain();
    @(negedge pclk);
    check("timeout_idle_ready", bus.cmd_ready, 1);
    check("timeout_idle_psel", bus.psel, 0);
    issue(1'b0, 32'h1000, 32'h0, TMO - 1, 1'b0, 32'h0000_0005, 1'b0, 3 + TMO - 1);
    drop();
    drain();
`else
    issue(1'b0, 32'h1000, 32'h0, 10, 1'b0, 32'h0000_0005, 1'b0, 13);
    drop();
    drain();
    @(negedge pclk);
    check("long_wait_idle_ready", bus.cmd_ready, 1);
`endif

    for (int k = 0; k < 60; k++) begin
      w     = 1'($urandom_range(0, 1));
      a     = 32'h100 + 32'(4 * $urandom_range(0, 7));
      d     = $urandom;
      waits = $urandom_range(0, 3);
      err   = ($urandom_range(0, 7) == 0);
      erd   = w ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
      issue(w, a, d, waits, err, erd, err, 3 + waits);
      if ($urandom_range(0, 1) == 1) begin
        drop();
        repeat ($urandom_range(0, 2)) @(posedge pclk);
      end
    end
    drop();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
